// File: rtl/mult_pipeline_sr_if.sv
// mult_pipeline_sr_if: operand/result valid-ready streams of the pipelined multiplier
// master drives operands and out_ready; slave (the multiplier) drives in_ready and the result side.
interface mult_pipeline_sr_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         in_valid;
    logic         in_ready;
    logic         signed_mode;
    logic [N-1:0] mult1;
    logic [M-1:0] mult2;
    logic         out_valid;
    logic         out_ready;
    logic [N+M-1:0] result;
    logic         result_signed;
    modport master (
        output in_valid, signed_mode, mult1, mult2, out_ready,
        input  in_ready, out_valid, result, result_signed
    );
    modport slave (
        input  in_valid, signed_mode, mult1, mult2, out_ready,
        output in_ready, out_valid, result, result_signed
    );
endinterface

// File: rtl/mult_pipeline_sr.sv
// mult_pipeline_sr: shift-and-add pipelined multiplier, per-transaction signed mode, valid/ready with bubble collapsing
// clk/rst: rising-edge clock, synchronous active-high reset.
// bus (slave): in_valid/in_ready + signed_mode/mult1/mult2 in; out_valid/out_ready + result/result_signed out.
// occupancy: number of stages holding a transaction.
module mult_pipeline_sr #(
    parameter int N   = 8,
    parameter int M   = 4,
    parameter int BPS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    mult_pipeline_sr_if.slave           bus,
    output logic [$clog2(M/BPS+1)-1:0]  occupancy
);
    localparam int W  = N + M;
    localparam int S  = M / BPS;
    localparam int OW = $clog2(S + 1);

    // Adds the partial products of the BPS multiplier bits sitting at the bottom of r.
    // In signed mode the multiplier's top bit has negative weight, so it is subtracted.
    function automatic logic [W-1:0] step(input logic [W-1:0] mc, input logic [M-1:0] r,
                                          input logic [W-1:0] s, input logic sg, input int k);
        logic [W-1:0] acc;
        acc = s;
        for (int j = 0; j < BPS; j++)
            if (r[j]) acc = (sg && k * BPS + j == M - 1) ? acc - (mc << j) : acc + (mc << j);
        return acc;
    endfunction

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic         v, sg, adv, p_v, p_sg;
        logic [W-1:0] sum, p_mc, p_sum;
        logic [M-1:0] p_rem;
        if (k == 0) begin : g_src
            assign p_v   = bus.in_valid;
            assign p_sg  = bus.signed_mode;
            assign p_mc  = {{M{bus.signed_mode & bus.mult1[N-1]}}, bus.mult1};
            assign p_rem = bus.mult2;
            assign p_sum = '0;
        end else begin : g_src
            assign p_v   = g_stage[k-1].v;
            assign p_sg  = g_stage[k-1].sg;
            assign p_mc  = g_stage[k-1].g_fwd.mc;
            assign p_rem = g_stage[k-1].g_fwd.rem;
            assign p_sum = g_stage[k-1].sum;
        end
        // A stage moves when it is empty or its successor moves, so bubbles are squeezed out.
        if (k == S - 1) begin : g_adv
            assign adv = !v || bus.out_ready;
        end else begin : g_adv
            assign adv = !v || g_stage[k+1].adv;
        end
        // The last stage only needs the sum; multiplicand and remaining bits are forwarded otherwise.
        if (k < S - 1) begin : g_fwd
            logic [W-1:0] mc;
            logic [M-1:0] rem;
            always_ff @(posedge clk)
                if (adv) begin
                    mc  <= p_mc << BPS;
                    rem <= p_rem >> BPS;
                end
        end
        always_ff @(posedge clk)
            if (rst) begin
                v   <= 1'b0;
                sg  <= 1'b0;
                sum <= '0;
            end else if (adv) begin
                v   <= p_v;
                sg  <= p_sg;
                sum <= step(p_mc, p_rem, p_sum, p_sg, k);
            end
    end

    logic in_fire, out_fire;

    assign bus.in_ready      = g_stage[0].adv;
    assign bus.out_valid     = g_stage[S-1].v;
    assign bus.result        = g_stage[S-1].sum;
    assign bus.result_signed = g_stage[S-1].sg;
    assign in_fire           = bus.in_valid && g_stage[0].adv;
    assign out_fire          = g_stage[S-1].v && bus.out_ready;

    always_ff @(posedge clk)
        if (rst) occupancy <= '0;
        else if (in_fire && !out_fire) occupancy <= occupancy + OW'(1);
        else if (!in_fire && out_fire) occupancy <= occupancy - OW'(1);
endmodule

// File: tb/tb_mult_pipeline_sr.sv
// tb_mult_pipeline_sr: directed checks of the pipelined multiplier in three configurations
module tb_mult_pipeline_sr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    mult_pipeline_sr_if #(.N(8),  .M(4)) b0 ();
    mult_pipeline_sr_if #(.N(8),  .M(4)) b1 ();
    mult_pipeline_sr_if #(.N(16), .M(8)) b2 ();
    logic [2:0] o0;
    logic [1:0] o1, o2;

    mult_pipeline_sr #(.N(8),  .M(4), .BPS(1)) d0 (.clk(clk), .rst(rst), .bus(b0), .occupancy(o0));
    mult_pipeline_sr #(.N(8),  .M(4), .BPS(2)) d1 (.clk(clk), .rst(rst), .bus(b1), .occupancy(o1));
    mult_pipeline_sr #(.N(16), .M(8), .BPS(4)) d2 (.clk(clk), .rst(rst), .bus(b2), .occupancy(o2));

    function automatic logic [11:0] prod12(input logic [7:0] a, input logic [3:0] b, input logic s);
        logic [11:0] x, y;
        x = {{4{s & a[7]}}, a};
        y = {{8{s & b[3]}}, b};
        return 12'(x * y);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", b0.out_valid); else passed++;
        total++; if (o0 !== 3'd0) $display("FAIL reset_occupancy: got %0d expected 0", o0); else passed++;
        total++; if (b0.result !== 12'h000) $display("FAIL reset_result: got %h expected 000", b0.result); else passed++;
        total++; if (b0.result_signed !== 1'b0) $display("FAIL reset_result_signed: got %b expected 0", b0.result_signed); else passed++;
        rst = 1'b0;
        tick;
        total++; if (b0.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", b0.in_ready); else passed++;
        total++; if (b1.in_ready !== 1'b1 || b2.in_ready !== 1'b1) $display("FAIL reset_in_ready_sweep: got %b%b expected 11", b1.in_ready, b2.in_ready); else passed++;
    endtask

    task automatic test_unsigned;
        int lat;
        b0.in_valid = 1'b1; b0.signed_mode = 1'b0; b0.mult1 = 8'hFF; b0.mult2 = 4'hF;
        #1;
        total++; if (b0.in_ready !== 1'b1) $display("FAIL unsigned_in_ready: got %b expected 1", b0.in_ready); else passed++;
        tick;
        b0.in_valid = 1'b0;
        lat = 1;
        while (!b0.out_valid && lat < 10) begin
            tick;
            lat++;
        end
        total++; if (lat != 4) $display("FAIL unsigned_latency: got %0d expected 4", lat); else passed++;
        total++; if (b0.result !== 12'hEF1) $display("FAIL unsigned_result: got %h expected ef1", b0.result); else passed++;
        total++; if (b0.result_signed !== 1'b0) $display("FAIL unsigned_result_signed: got %b expected 0", b0.result_signed); else passed++;
        tick;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL unsigned_drained: got %b expected 0", b0.out_valid); else passed++;
    endtask

    task automatic test_signed;
        logic [7:0]  ta [3];
        logic [3:0]  tb [3];
        logic [11:0] te [3];
        int lat;
        ta = '{8'h80, 8'h7F, 8'hFF};
        tb = '{4'h8, 4'h8, 4'h1};
        te = '{12'h400, 12'hC08, 12'hFFF};
        for (int i = 0; i < 3; i++) begin
            b0.in_valid = 1'b1; b0.signed_mode = 1'b1; b0.mult1 = ta[i]; b0.mult2 = tb[i];
            tick;
            b0.in_valid = 1'b0;
            lat = 1;
            while (!b0.out_valid && lat < 10) begin
                tick;
                lat++;
            end
            total++; if (lat != 4) $display("FAIL signed_latency[%0d]: got %0d expected 4", i, lat); else passed++;
            total++; if (b0.result !== te[i]) $display("FAIL signed_result[%0d]: got %h expected %h", i, b0.result, te[i]); else passed++;
            total++; if (b0.result_signed !== 1'b1) $display("FAIL signed_flag[%0d]: got %b expected 1", i, b0.result_signed); else passed++;
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  sa [32];
        logic [3:0]  sb [32];
        logic        ss [32];
        logic [11:0] se [32];
        for (int i = 0; i < 32; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 4'($urandom);
            ss[i] = i[0];
            se[i] = prod12(sa[i], sb[i], ss[i]);
        end
        b0.out_ready = 1'b1;
        for (int c = 0; c < 36; c++) begin
            b0.in_valid = (c < 32);
            if (c < 32) begin
                b0.mult1 = sa[c]; b0.mult2 = sb[c]; b0.signed_mode = ss[c];
            end
            tick;
            if (c >= 3 && c <= 34) begin
                total++; if (b0.out_valid !== 1'b1) $display("FAIL stream_gap[%0d]: out_valid %b expected 1", c, b0.out_valid); else passed++;
                total++; if (b0.result !== se[c-3] || b0.result_signed !== ss[c-3])
                    $display("FAIL stream_result[%0d]: got %h/%b expected %h/%b", c - 3, b0.result, b0.result_signed, se[c-3], ss[c-3]);
                else passed++;
            end else begin
                total++; if (b0.out_valid !== 1'b0) $display("FAIL stream_idle[%0d]: out_valid %b expected 0", c, b0.out_valid); else passed++;
            end
            if (c >= 3 && c <= 31) begin
                total++; if (o0 !== 3'd4) $display("FAIL stream_occupancy[%0d]: got %0d expected 4", c, o0); else passed++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  pa [6];
        logic [3:0]  pb [6];
        logic        ps [6];
        logic [11:0] pe [6];
        int idx, k;
        logic fire;
        pa = '{8'hFF, 8'h80, 8'h12, 8'h7F, 8'hA5, 8'h01};
        pb = '{4'hF, 4'h8, 4'h3, 4'h8, 4'hC, 4'h7};
        ps = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) pe[i] = prod12(pa[i], pb[i], ps[i]);
        b0.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            b0.in_valid = (c != 1);
            b0.mult1 = pa[idx]; b0.mult2 = pb[idx]; b0.signed_mode = ps[idx];
            #1;
            fire = b0.in_valid && b0.in_ready;
            tick;
            if (fire) idx++;
            if (c >= 3) begin
                total++; if (b0.out_valid !== 1'b1 || b0.result !== pe[0])
                    $display("FAIL bp_held[%0d]: got %b/%h expected 1/%h", c, b0.out_valid, b0.result, pe[0]);
                else passed++;
            end
            if (c == 4) begin
                total++; if (o0 !== 3'd4) $display("FAIL bp_bubble_collapse: occupancy %0d expected 4", o0); else passed++;
            end
        end
        total++; if (idx != 4) $display("FAIL bp_accepted: got %0d expected 4", idx); else passed++;
        total++; if (b0.in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b expected 0", b0.in_ready); else passed++;
        total++; if (o0 !== 3'd4) $display("FAIL bp_full_occupancy: got %0d expected 4", o0); else passed++;
        b0.out_ready = 1'b1;
        #1;
        total++; if (b0.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", b0.in_ready); else passed++;
        tick;
        idx++;
        b0.out_ready = 1'b0;
        total++; if (o0 !== 3'd4) $display("FAIL bp_swap_occupancy: got %0d expected 4", o0); else passed++;
        total++; if (b0.out_valid !== 1'b1 || b0.result !== pe[1])
            $display("FAIL bp_swap_result: got %b/%h expected 1/%h", b0.out_valid, b0.result, pe[1]);
        else passed++;
        b0.mult1 = pa[idx]; b0.mult2 = pb[idx]; b0.signed_mode = ps[idx];
        #1;
        total++; if (b0.in_ready !== 1'b0) $display("FAIL bp_refull_in_ready: got %b expected 0", b0.in_ready); else passed++;
        b0.out_ready = 1'b1;
        k = 1;
        for (int c = 0; c < 20 && k < 6; c++) begin
            #1;
            if (b0.out_valid) begin
                total++; if (b0.result !== pe[k] || b0.result_signed !== ps[k])
                    $display("FAIL bp_drain[%0d]: got %h/%b expected %h/%b", k, b0.result, b0.result_signed, pe[k], ps[k]);
                else passed++;
                k++;
            end
            fire = b0.in_valid && b0.in_ready;
            tick;
            if (fire) b0.in_valid = 1'b0;
        end
        total++; if (k != 6) $display("FAIL bp_drain_count: got %0d expected 6", k); else passed++;
        total++; if (o0 !== 3'd0) $display("FAIL bp_empty_occupancy: got %0d expected 0", o0); else passed++;
    endtask

    task automatic test_reset_mid;
        int seen;
        b0.out_ready = 1'b1;
        b0.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b0.mult1 = 8'(8'h31 + i * 8'h40); b0.mult2 = 4'(5 + i); b0.signed_mode = i[0];
            tick;
        end
        b0.in_valid = 1'b0;
        total++; if (o0 !== 3'd3 || b0.out_valid !== 1'b0) $display("FAIL mid_inflight: occ %0d valid %b expected 3/0", o0, b0.out_valid); else passed++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", b0.out_valid); else passed++;
        total++; if (o0 !== 3'd0) $display("FAIL mid_occupancy: got %0d expected 0", o0); else passed++;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (b0.out_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL mid_stale: got %0d outputs expected 0", seen); else passed++;
        total++; if (b0.in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b expected 1", b0.in_ready); else passed++;
    endtask

    task automatic test_sweep;
        logic [7:0]  a1 [2];
        logic [3:0]  m1 [2];
        logic [11:0] e1 [2];
        logic [15:0] a2 [2];
        logic [7:0]  m2 [2];
        logic [23:0] e2 [2];
        logic        sv [2];
        logic [11:0] r1;
        logic [23:0] r2;
        logic        f1, f2;
        int l1, l2;
        a1 = '{8'h80, 8'hFF};     m1 = '{4'h8, 4'hF};   e1 = '{12'h400, 12'hEF1};
        a2 = '{16'h8000, 16'hFFFF}; m2 = '{8'h80, 8'hFF}; e2 = '{24'h400000, 24'hFEFF01};
        sv = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            b1.in_valid = 1'b1; b1.signed_mode = sv[i]; b1.mult1 = a1[i]; b1.mult2 = m1[i];
            b2.in_valid = 1'b1; b2.signed_mode = sv[i]; b2.mult1 = a2[i]; b2.mult2 = m2[i];
            tick;
            b1.in_valid = 1'b0;
            b2.in_valid = 1'b0;
            l1 = 0; l2 = 0; r1 = '0; r2 = '0; f1 = 1'b0; f2 = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                if (b1.out_valid && l1 == 0) begin l1 = c; r1 = b1.result; f1 = b1.result_signed; end
                if (b2.out_valid && l2 == 0) begin l2 = c; r2 = b2.result; f2 = b2.result_signed; end
                if (l1 != 0 && l2 != 0) break;
                tick;
            end
            total++; if (l1 != 2) $display("FAIL sweep_bps2_latency[%0d]: got %0d expected 2", i, l1); else passed++;
            total++; if (r1 !== e1[i] || f1 !== sv[i]) $display("FAIL sweep_bps2_result[%0d]: got %h/%b expected %h/%b", i, r1, f1, e1[i], sv[i]); else passed++;
            total++; if (l2 != 2) $display("FAIL sweep_n16_latency[%0d]: got %0d expected 2", i, l2); else passed++;
            total++; if (r2 !== e2[i] || f2 !== sv[i]) $display("FAIL sweep_n16_result[%0d]: got %h/%b expected %h/%b", i, r2, f2, e2[i], sv[i]); else passed++;
            tick;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    initial begin
        b0.in_valid = 1'b0; b0.signed_mode = 1'b0; b0.mult1 = '0; b0.mult2 = '0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.signed_mode = 1'b0; b1.mult1 = '0; b1.mult2 = '0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.signed_mode = 1'b0; b2.mult1 = '0; b2.mult2 = '0; b2.out_ready = 1'b1;
        test_reset;
        test_unsigned;
        test_signed;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_sweep;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mult_pipeline_sr.md
Name: mult_pipeline_sr

Overview:
- Parametrised shift-and-add pipelined multiplier. Successor to the fixed 1-bit-per-stage pipeline.
- Adds a signed/unsigned mode selected per operand pair, configurable multiplier bits retired per stage, and valid/ready backpressure with bubble collapsing.
- Sits between producers and consumers that both use valid/ready streams. Sustains one product per cycle when not stalled.

Parameters:
N, 8, multiplicand (mult1) width, >=2
M, 4, multiplier (mult2) width, >=2
BPS, 1, multiplier bits retired per stage; M must be divisible by BPS; stage count S = M/BPS

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair presented
in_ready  output  1  pipeline can accept operand pair this cycle
signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with the operands
mult1  input  N  multiplicand
mult2  input  M  multiplier
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  N+M  product
result_signed  output  1  signed_mode of the transaction on result
occupancy  output  clog2(S+1)  number of valid stages holding transactions

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous, active-high, and takes priority over all other activity. On the rst cycle, every stage valid bit clears. out_valid=0, occupancy=0, result=0, result_signed=0. in_ready=1 from the first cycle after rst deasserts.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - out_valid, result and result_signed stay stable until the transfer completes.
  - in_ready has no combinational dependence on in_valid.
- Pipeline: S registered stages. Each stage holds a valid bit, shifted multiplicand (N+M bits), remaining multiplier bits, partial sum (N+M bits) and a mode bit.
- Per-stage computation: stage k adds the partial products for multiplier bits [k*BPS +: BPS] to its partial sum.
  - Unsigned mode: mult1 is zero-extended to N+M bits.
  - Signed mode: mult1 is sign-extended to N+M bits, and the partial product of multiplier bit M-1 is subtracted instead of added.
  - All arithmetic is modulo 2^(N+M). The product always fits exactly.
- Latency: S cycles from the input transfer to out_valid, when no stall occurs. The output register is the last stage.
- Bubble collapsing: stage k advances when it is empty, or when stage k+1 advances or is empty. The last stage advances when it is empty or out_ready=1. in_ready equals the advance condition of stage 0.
  - Consequences: a stall holds only the stages behind the blocked one, and empty stages fill while the output is blocked.
- Throughput: 1 transfer per cycle with out_ready held high.
- Simultaneous events:
  - When the pipeline is full with out_valid=1, out_ready=1 and in_valid=1, both transfers occur in the same cycle.
  - occupancy updates as +1 on an input-only transfer, -1 on an output-only transfer, and unchanged when both or neither occur.
- Full condition: all S stages valid and out_ready=0, giving in_ready=0. A held in_valid is accepted on the first cycle out_ready returns high.
- Mode is per transaction: changing signed_mode between back-to-back inputs must not corrupt in-flight results.
- Reset mid-operation discards all in-flight transactions with no output produced. The consumer sees out_valid=0 on the cycle after rst.
- Edge operands to support:
  - Unsigned: 0 and all-ones.
  - Signed: the most-negative values. With N=8, M=4, -128 * -8 = +1024, which fits in 12 bits.

Test Plan:
- Unsigned, N=8 M=4 BPS=1, out_ready=1. Apply mult1=255, mult2=15 -> result=0xEF1 (3825) with result_signed=0, out_valid exactly 4 cycles after the transfer.
- Signed, same configuration.
  - mult1=0x80, mult2=0x8 -> 0x400.
  - mult1=0x7F, mult2=0x8 -> 0xC08 (-1016).
  - mult1=0xFF, mult2=0x1 -> 0xFFF.
- Back-to-back stream of 32 random pairs with signed_mode toggling each cycle, out_ready=1 -> 32 results in order, matching the model. No gaps after the first output. occupancy stays at 4.
- Backpressure: hold out_ready=0 while feeding 6 pairs -> 4 accepted, then in_ready=0 and occupancy=4, with the first result held stable.
  - Then raise out_ready for 1 cycle -> exactly one output and one input transfer, occupancy stays 4.
  - Insert a bubble before the stall and confirm it collapses.
- Reset mid-operation: assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 and occupancy=0 on the next cycle, and no stale results appear afterwards.
- Parameter sweep N=8 M=4 BPS=2 -> latency 2 cycles. With N=16 M=8 BPS=4, signed 0x8000 * 0x80 -> 0x400000, with latency 2 cycles.
